btb_ctrl: RTL and testbench
===========================

BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 SHALL have parameter N_ENTRY, default 32, BTB depth (power of two); IDX_W = log2(N_ENTRY), default 5.
REQ-002 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-003 SHALL have port i_rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have ports i_upd_valid / i_upd_pc / i_upd_target / i_upd_taken, input, 1/32/32/1, resolved control-transfer from EX.
REQ-005 SHALL have ports i_pred_taken / i_pred_pc, input, 1/32, prediction that travelled with the EX instruction.
REQ-006 SHALL have ports i_flush_req (input, 1, invalidate whole BTB: interrupt entry or fence.i) and o_flush_ack (output, 1, one-cycle done pulse).
REQ-007 SHALL have write-port outputs o_btb_we (1), o_btb_inv (1), o_btb_idx (IDX_W), o_btb_tag (32-2-IDX_W), o_btb_target (32) and o_btb_taken (1), driving one BTB entry write per cycle.
REQ-008 SHALL have outputs o_redirect (1) and o_redirect_pc (32), a mispredict recovery pulse to the fetch stage.
REQ-009 SHALL have outputs o_busy (1, sweep in progress) and o_drop_cnt (8, dropped updates, saturating).

Function
REQ-010 SHALL implement FSM states INIT, IDLE and FLUSH.
REQ-011 INIT SHALL sweep idx 0..N_ENTRY-1, one entry per cycle, with o_btb_we=1, o_btb_inv=1 and the other write fields 0, then go to IDLE (N_ENTRY cycles).
REQ-012 IDLE + i_flush_req SHALL enter FLUSH, which sweeps identically to INIT and pulses o_flush_ack the cycle after the last invalidate.
REQ-013 i_flush_req during INIT/FLUSH SHALL be latched (one bit) and acked at that sweep's end without an extra sweep.
REQ-014 IDLE + i_upd_valid SHALL write the entry the next cycle: idx = pc[IDX_W+1:2], tag = pc[31:IDX_W+2], target, taken, we=1, inv=0 (1-cycle latency, registered).
REQ-015 In IDLE, the taken field SHALL carry the resolved direction; the 2-bit counter update remains in the BTB.
REQ-016 i_upd_valid during a sweep SHALL be captured in a single-entry pending buffer if it is empty.
REQ-017 The pending buffer SHALL be written the first IDLE cycle after the sweep, ahead of any new update.
REQ-018 If the pending buffer is full, the new update SHALL be dropped and o_drop_cnt incremented, saturating at 255.
REQ-019 A new update arriving while pending drains in IDLE SHALL be held in a second stage register and written the next cycle, so no update is lost in IDLE.
REQ-020 i_flush_req and i_upd_valid in the same IDLE cycle: the flush SHALL win and the update SHALL go to the pending buffer.
REQ-020a A buffered update SHALL be discarded when its flush sweep completes, because a flush invalidates all state.
REQ-021 Mispredict SHALL be detected when i_upd_valid && (i_upd_taken != i_pred_taken || (i_upd_taken && i_upd_target != i_pred_pc)).
REQ-022 On mispredict, o_redirect SHALL pulse 1 cycle later with o_redirect_pc = taken ? target : pc+4, modulo 2^32.
REQ-023 Redirect SHALL be generated in every state, including during a sweep.
REQ-024 o_busy SHALL be 1 exactly in INIT and FLUSH.
REQ-025 The sweep counter SHALL stop at N_ENTRY-1 without wrapping into a second pass.

Reset
REQ-026 While i_rst_n=0 at a clock edge: state SHALL be INIT and counter 0.
REQ-027 While i_rst_n=0 at a clock edge: the pending buffer, stage register and flush latch SHALL be cleared.
REQ-028 While i_rst_n=0 at a clock edge: o_btb_we, o_btb_inv, o_redirect, o_flush_ack and o_drop_cnt SHALL be 0.
REQ-029 While i_rst_n=0 at a clock edge: o_busy SHALL be 1 and all data outputs 0.
REQ-030 Reset asserted mid-sweep or mid-drain SHALL restart the INIT sweep from idx 0, and the buffered update SHALL be lost.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, N_ENTRY/IDX_W defaults, and the opcode constants for B_type, JAL and JALR.
REQ-032 A shared package SHALL hold a packed update struct {pc, target, taken}.
REQ-033 One sub-module SHALL be used: btb_sweep_cnt (index counter with start/done), reused by INIT and FLUSH.

Verification
REQ-034 Release reset -> o_busy=1 for 32 cycles, inv writes idx 0..31 in order, then o_busy=0, with no flush_ack.
REQ-035 IDLE, update pc=0x0000_0084, target=0x0000_0100, taken=1 -> next cycle we=1, idx=1, tag=0x0000001, target=0x100.
REQ-036 pred_taken=0 and taken=1 for pc=0x40, target=0x80 -> o_redirect=1 with pc=0x80; pred_taken=1 and taken=0 -> o_redirect_pc=0x44.
REQ-037 flush_req at sweep idx 10 of INIT, plus two updates during the sweep -> one ack after idx 31, the first update is discarded, the second is dropped, and o_drop_cnt=1.
REQ-038 Flush and update in the same IDLE cycle -> 32 inv writes, then flush_ack, then no BTB write for the update.
REQ-039 Reset asserted at sweep idx 20 -> sweep restarts at idx 0, with o_drop_cnt=0.

Source files
------------

// File: rtl/btb_ctrl_pkg.sv
// Shared types and constants for the BTB write-port controller.
// Holds the FSM encoding, default geometry and the update record.
package btb_ctrl_pkg;

  localparam int N_ENTRY_DEF = 32;
  localparam int IDX_W_DEF   = $clog2(N_ENTRY_DEF);

  // RV32 opcodes of the instructions that produce BTB updates
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_t;

  function automatic logic is_cti(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/btb_ctrl_if.sv
// Bundle between EX / fetch / BTB array and the BTB controller.
// master = environment side, slave = controller side.
interface btb_ctrl_if #(
  parameter int IDX_W = 5
);

  logic                  i_upd_valid;
  logic [31:0]           i_upd_pc;
  logic [31:0]           i_upd_target;
  logic                  i_upd_taken;
  logic                  i_pred_taken;
  logic [31:0]           i_pred_pc;
  logic                  i_flush_req;
  logic                  o_flush_ack;
  logic                  o_btb_we;
  logic                  o_btb_inv;
  logic [IDX_W-1:0]      o_btb_idx;
  logic [32-2-IDX_W-1:0] o_btb_tag;
  logic [31:0]           o_btb_target;
  logic                  o_btb_taken;
  logic                  o_redirect;
  logic [31:0]           o_redirect_pc;
  logic                  o_busy;
  logic [7:0]            o_drop_cnt;

  modport slave (
    input  i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken,
    input  i_pred_taken, i_pred_pc, i_flush_req,
    output o_flush_ack, o_btb_we, o_btb_inv, o_btb_idx, o_btb_tag,
    output o_btb_target, o_btb_taken, o_redirect, o_redirect_pc,
    output o_busy, o_drop_cnt
  );

  modport master (
    output i_upd_valid, i_upd_pc, i_upd_target, i_upd_taken,
    output i_pred_taken, i_pred_pc, i_flush_req,
    input  o_flush_ack, o_btb_we, o_btb_inv, o_btb_idx, o_btb_tag,
    input  o_btb_target, o_btb_taken, o_redirect, o_redirect_pc,
    input  o_busy, o_drop_cnt
  );

endinterface

// File: rtl/btb_ctrl_sweep_cnt.sv
// Invalidate-sweep index counter shared by the INIT and FLUSH sweeps.
// Counts up while enabled and parks on the last index instead of wrapping.
module btb_sweep_cnt
  import btb_ctrl_pkg::*;
#(
  parameter int N_ENTRY = N_ENTRY_DEF,
  parameter int IDX_W   = $clog2(N_ENTRY)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             start,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRY - 1);

  logic [IDX_W-1:0] cnt_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != LAST_IDX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign idx  = cnt_reg;
  assign done = (cnt_reg == LAST_IDX);

endmodule

// File: rtl/btb_ctrl.sv
// BTB write-port controller: power-up/flush invalidate sweeps, buffered
// resolved-branch updates and one-cycle mispredict redirects. All outputs registered.
module btb_ctrl
  import btb_ctrl_pkg::*;
#(
  parameter int N_ENTRY = N_ENTRY_DEF,
  parameter int IDX_W   = $clog2(N_ENTRY)
) (
  input logic        i_clk,
  input logic        i_rst_n,
  btb_ctrl_if.slave  bus
);

  localparam int TAG_W = 32 - 2 - IDX_W;

  state_t           state_reg, state_next;
  upd_t             upd_in;
  upd_t             pend_reg, pend_next;
  logic             pend_vld_reg, pend_vld_next;
  upd_t             stg_reg, stg_next;
  logic             stg_vld_reg, stg_vld_next;
  logic             flush_lat_reg, flush_lat_next;
  logic             ack_due_reg, ack_due_next;
  logic [7:0]       drop_cnt_reg, drop_cnt_next;

  logic             we_reg, inv_reg, taken_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [31:0]      target_reg;
  logic             redirect_reg, flush_ack_reg, busy_reg;
  logic [31:0]      redirect_pc_reg;

  logic             cnt_start, cnt_done;
  logic [IDX_W-1:0] cnt_idx;
  logic             sweep_we, upd_we, drop_inc, ack_next;
  upd_t             wr_upd;
  logic             mispredict;

  assign upd_in = {bus.i_upd_pc, bus.i_upd_target, bus.i_upd_taken};

  btb_sweep_cnt #(
    .N_ENTRY (N_ENTRY),
    .IDX_W   (IDX_W)
  ) u_sweep_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .start   (cnt_start),
    .en      (state_reg != ST_IDLE),
    .idx     (cnt_idx),
    .done    (cnt_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg     <= ST_INIT;
      pend_reg      <= '0;
      pend_vld_reg  <= 1'b0;
      stg_reg       <= '0;
      stg_vld_reg   <= 1'b0;
      flush_lat_reg <= 1'b0;
      ack_due_reg   <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= pend_next;
      pend_vld_reg  <= pend_vld_next;
      stg_reg       <= stg_next;
      stg_vld_reg   <= stg_vld_next;
      flush_lat_reg <= flush_lat_next;
      ack_due_reg   <= ack_due_next;
      drop_cnt_reg  <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pend_next      = pend_reg;
    pend_vld_next  = pend_vld_reg;
    stg_next       = stg_reg;
    stg_vld_next   = stg_vld_reg;
    flush_lat_next = flush_lat_reg;
    ack_due_next   = ack_due_reg;
    cnt_start      = 1'b0;
    sweep_we       = 1'b0;
    upd_we         = 1'b0;
    wr_upd         = '0;
    drop_inc       = 1'b0;
    ack_next       = 1'b0;

    case (state_reg)
      ST_INIT, ST_FLUSH: begin
        sweep_we = 1'b1;
        if (bus.i_flush_req) begin
          flush_lat_next = 1'b1;
        end
        if (bus.i_upd_valid) begin
          if (!pend_vld_reg) begin
            pend_vld_next = 1'b1;
            pend_next     = upd_in;
          end else begin
            drop_inc = 1'b1;
          end
        end
        if (cnt_done) begin
          state_next     = ST_IDLE;
          flush_lat_next = 1'b0;
          // A flush-terminated sweep owes an ack and wipes anything buffered
          if ((state_reg == ST_FLUSH) || flush_lat_reg || bus.i_flush_req) begin
            ack_due_next  = 1'b1;
            pend_vld_next = 1'b0;
            pend_next     = '0;
          end
        end
      end

      ST_IDLE: begin
        if (ack_due_reg) begin
          ack_next     = 1'b1;
          ack_due_next = 1'b0;
        end
        if (bus.i_flush_req) begin
          state_next    = ST_FLUSH;
          cnt_start     = 1'b1;
          pend_vld_next = bus.i_upd_valid;
          pend_next     = bus.i_upd_valid ? upd_in : '0;
          stg_vld_next  = 1'b0;
          stg_next      = '0;
        end else if (pend_vld_reg || stg_vld_reg) begin
          // Drain the oldest buffered update; a newcomer waits one cycle in the stage
          upd_we        = 1'b1;
          wr_upd        = pend_vld_reg ? pend_reg : stg_reg;
          pend_vld_next = 1'b0;
          pend_next     = '0;
          stg_vld_next  = bus.i_upd_valid;
          stg_next      = bus.i_upd_valid ? upd_in : '0;
        end else if (bus.i_upd_valid) begin
          upd_we = 1'b1;
          wr_upd = upd_in;
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase

    drop_cnt_next = (drop_inc && (drop_cnt_reg != 8'hFF)) ? drop_cnt_reg + 8'd1 : drop_cnt_reg;
  end

  assign mispredict = bus.i_upd_valid &&
                      ((bus.i_upd_taken != bus.i_pred_taken) ||
                       (bus.i_upd_taken && (bus.i_upd_target != bus.i_pred_pc)));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_reg          <= 1'b0;
      inv_reg         <= 1'b0;
      idx_reg         <= '0;
      tag_reg         <= '0;
      target_reg      <= '0;
      taken_reg       <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
      flush_ack_reg   <= 1'b0;
      busy_reg        <= 1'b1;
    end else begin
      we_reg          <= sweep_we | upd_we;
      inv_reg         <= sweep_we;
      idx_reg         <= sweep_we ? cnt_idx : (upd_we ? wr_upd.pc[IDX_W+1:2] : '0);
      tag_reg         <= upd_we ? wr_upd.pc[31:IDX_W+2] : '0;
      target_reg      <= upd_we ? wr_upd.target : '0;
      taken_reg       <= upd_we & wr_upd.taken;
      redirect_reg    <= mispredict;
      redirect_pc_reg <= !mispredict ? 32'd0 :
                         (bus.i_upd_taken ? bus.i_upd_target : bus.i_upd_pc + 32'd4);
      flush_ack_reg   <= ack_next;
      // Tracks the state of the cycle whose write is now on the port
      busy_reg        <= (state_reg != ST_IDLE);
    end
  end

  assign bus.o_btb_we      = we_reg;
  assign bus.o_btb_inv     = inv_reg;
  assign bus.o_btb_idx     = idx_reg;
  assign bus.o_btb_tag     = tag_reg;
  assign bus.o_btb_target  = target_reg;
  assign bus.o_btb_taken   = taken_reg;
  assign bus.o_redirect    = redirect_reg;
  assign bus.o_redirect_pc = redirect_pc_reg;
  assign bus.o_flush_ack   = flush_ack_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl: transaction-level reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_btb_ctrl;

  localparam int N     = 32;
  localparam int IDX_W = 5;
  localparam int TAG_W = 30 - IDX_W;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  btb_ctrl_if #(.IDX_W(IDX_W)) bus ();

  btb_ctrl #(.N_ENTRY(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          sweep_left, next_idx, drops;
  bit          ack_owed, ack_pend, model_valid;
  logic [64:0] pbuf[$];
  logic [64:0] wq[$];
  logic [64:0] w;
  logic [31:0] wpc;
  logic             e_we, e_inv, e_taken, e_redirect, e_ack, e_busy;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic [31:0]      e_target, e_rpc;
  logic [7:0]       e_drop;

  initial model_valid = 1'b0;

  always @(posedge clk) begin
    logic [64:0] u;
    u = {bus.i_upd_pc, bus.i_upd_target, bus.i_upd_taken};
    {e_we, e_inv, e_taken, e_redirect, e_ack, e_busy} = '0;
    e_idx = '0; e_tag = '0; e_target = '0; e_rpc = '0;
    if (!rst_n) begin
      e_busy = 1'b1;
      sweep_left = N; next_idx = 0; drops = 0;
      ack_owed = 1'b0; ack_pend = 1'b0;
      pbuf.delete(); wq.delete();
    end else begin
      if (bus.i_upd_valid && ((bus.i_upd_taken != bus.i_pred_taken) ||
          (bus.i_upd_taken && bus.i_upd_target != bus.i_pred_pc))) begin
        e_redirect = 1'b1;
        e_rpc = bus.i_upd_taken ? bus.i_upd_target : bus.i_upd_pc + 32'd4;
      end
      if (sweep_left > 0) begin
        e_busy = 1'b1; e_we = 1'b1; e_inv = 1'b1;
        e_idx = IDX_W'(next_idx);
        next_idx++; sweep_left--;
        if (bus.i_flush_req) ack_owed = 1'b1;
        if (bus.i_upd_valid) begin
          if (pbuf.size() == 0) pbuf.push_back(u);
          else if (drops < 255) drops++;
        end
        if (sweep_left == 0) begin
          if (ack_owed) begin
            ack_pend = 1'b1;
            pbuf.delete();
          end else begin
            while (pbuf.size() > 0) wq.push_back(pbuf.pop_front());
          end
          ack_owed = 1'b0;
        end
      end else begin
        e_ack = ack_pend; ack_pend = 1'b0;
        if (bus.i_flush_req) begin
          sweep_left = N; next_idx = 0; ack_owed = 1'b1;
          wq.delete(); pbuf.delete();
          if (bus.i_upd_valid) pbuf.push_back(u);
        end else begin
          if (bus.i_upd_valid) wq.push_back(u);
          if (wq.size() > 0) begin
            w = wq.pop_front();
            wpc = w[64:33];
            e_we = 1'b1;
            e_idx = IDX_W'((wpc >> 2) % N);
            e_tag = TAG_W'(wpc >> (IDX_W + 2));
            e_target = w[32:1];
            e_taken = w[0];
          end
        end
      end
    end
    e_drop = 8'(drops);
    model_valid = 1'b1;
  end

  // ---------------- helpers ----------------
  int cnt_inv = 0, cnt_updw = 0, cnt_ack = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.i_upd_valid = 1'b0; bus.i_upd_pc = '0; bus.i_upd_target = '0;
    bus.i_upd_taken = 1'b0; bus.i_pred_taken = 1'b0; bus.i_pred_pc = '0;
    bus.i_flush_req = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn,
                         input logic ptkn, input logic [31:0] ppc);
    bus.i_upd_valid = 1'b1; bus.i_upd_pc = pc; bus.i_upd_target = tgt;
    bus.i_upd_taken = tkn; bus.i_pred_taken = ptkn; bus.i_pred_pc = ppc;
    $display("TXN upd pc=%h target=%h taken=%0b pred_taken=%0b pred_pc=%h flush=%0b",
             pc, tgt, tkn, ptkn, ppc, bus.i_flush_req);
  endtask

  task automatic wait_ack(input string name);
    int k;
    for (k = 0; k < 60 && !bus.o_flush_ack; k++) tick(1);
    chk(name, bus.o_flush_ack, 1'b1);
  endtask

  int b_inv, b_updw, b_ack;

  initial begin
    rst_n = 1'b0;
    clear_in();
    fork
      forever begin
        @(negedge clk);
        if (model_valid) begin
          chk("cycle_outputs",
              {bus.o_btb_we, bus.o_btb_inv, bus.o_btb_idx, bus.o_btb_tag, bus.o_btb_target,
               bus.o_btb_taken, bus.o_redirect, bus.o_redirect_pc, bus.o_flush_ack,
               bus.o_busy, bus.o_drop_cnt},
              {e_we, e_inv, e_idx, e_tag, e_target, e_taken, e_redirect, e_rpc, e_ack,
               e_busy, e_drop});
          if (bus.o_btb_we && bus.o_btb_inv) cnt_inv++;
          if (bus.o_btb_we && !bus.o_btb_inv) cnt_updw++;
          if (bus.o_flush_ack) cnt_ack++;
        end
      end
    join_none

    // Reset and power-up sweep
    tick(3);
    chk("reset_busy", bus.o_busy, 1'b1);
    chk("reset_we", bus.o_btb_we, 1'b0);
    rst_n = 1'b1;
    b_inv = cnt_inv; b_ack = cnt_ack;
    tick(1);
    chk("init_first_idx", {bus.o_btb_inv, bus.o_btb_idx}, {1'b1, 5'd0});
    tick(31);
    chk("init_last_idx", {bus.o_busy, bus.o_btb_idx}, {1'b1, 5'd31});
    tick(1);
    chk("init_done_busy", bus.o_busy, 1'b0);
    chk("init_inv_count", cnt_inv - b_inv, 32);
    chk("init_no_ack", cnt_ack - b_ack, 0);

    // Plain update written one cycle later
    set_upd(32'h84, 32'h100, 1'b1, 1'b1, 32'h100);
    tick(1); clear_in();
    chk("upd_write", {bus.o_btb_we, bus.o_btb_inv, bus.o_btb_idx, bus.o_btb_tag,
                      bus.o_btb_target, bus.o_btb_taken, bus.o_redirect},
        {1'b1, 1'b0, 5'd1, 25'd1, 32'h100, 1'b1, 1'b0});

    // Redirect cases
    set_upd(32'h40, 32'h80, 1'b1, 1'b0, 32'h0);
    tick(1);
    chk("redir_taken", {bus.o_redirect, bus.o_redirect_pc, bus.o_btb_idx}, {1'b1, 32'h80, 5'd16});
    set_upd(32'h40, 32'h80, 1'b0, 1'b1, 32'h80);
    tick(1);
    chk("redir_not_taken", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 32'h44});
    set_upd(32'hFFFF_FFFC, 32'h10, 1'b0, 1'b1, 32'h10);
    tick(1);
    chk("redir_wrap", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 32'h0});
    set_upd(32'h40, 32'h80, 1'b1, 1'b1, 32'h90);
    tick(1);
    chk("redir_bad_target", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 32'h80});
    set_upd(32'h40, 32'h80, 1'b1, 1'b1, 32'h80);
    tick(1); clear_in();
    chk("no_redirect", bus.o_redirect, 1'b0);
    tick(2);

    // Flush and update in the same IDLE cycle
    b_inv = cnt_inv; b_updw = cnt_updw; b_ack = cnt_ack;
    bus.i_flush_req = 1'b1;
    set_upd(32'h300, 32'h400, 1'b1, 1'b1, 32'h400);
    tick(1); clear_in();
    wait_ack("flush_upd_ack");
    chk("flush_upd_inv", cnt_inv - b_inv, 32);
    tick(3);
    chk("flush_upd_nowrite", cnt_updw - b_updw, 0);
    chk("flush_upd_one_ack", cnt_ack - b_ack, 1);

    // Flush request during a FLUSH sweep: one ack, no second sweep
    b_inv = cnt_inv; b_ack = cnt_ack;
    bus.i_flush_req = 1'b1; tick(1); clear_in();
    tick(10);
    bus.i_flush_req = 1'b1; tick(1); clear_in();
    wait_ack("flush_in_flush_ack");
    tick(3);
    chk("flush_in_flush_acks", cnt_ack - b_ack, 1);
    chk("flush_in_flush_inv", cnt_inv - b_inv, 32);

    // Flush at INIT idx 10 with two updates during the sweep
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    b_inv = cnt_inv; b_updw = cnt_updw; b_ack = cnt_ack;
    tick(5);
    set_upd(32'h200, 32'h240, 1'b1, 1'b1, 32'h240); tick(1); clear_in();
    tick(4);
    bus.i_flush_req = 1'b1; tick(1); clear_in();
    tick(4);
    set_upd(32'h208, 32'h280, 1'b1, 1'b1, 32'h280); tick(1); clear_in();
    wait_ack("init_flush_ack");
    chk("init_flush_drop", bus.o_drop_cnt, 8'd1);
    chk("init_flush_inv", cnt_inv - b_inv, 32);
    tick(3);
    chk("init_flush_nowrite", cnt_updw - b_updw, 0);
    chk("init_flush_one_ack", cnt_ack - b_ack, 1);

    // Reset at sweep idx 20, then pending drain and stage hand-off
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    tick(21);
    chk("mid_sweep_idx", bus.o_btb_idx, 5'd20);
    rst_n = 1'b0; tick(1);
    chk("mid_reset_we", {bus.o_btb_we, bus.o_busy}, {1'b0, 1'b1});
    rst_n = 1'b1; tick(1);
    chk("restart_idx0", {bus.o_btb_inv, bus.o_btb_idx, bus.o_drop_cnt}, {1'b1, 5'd0, 8'd0});
    tick(4);
    set_upd(32'h504, 32'h600, 1'b1, 1'b1, 32'h600); tick(1); clear_in();
    tick(1);
    set_upd(32'h50C, 32'h610, 1'b1, 1'b1, 32'h610); tick(1); clear_in();
    chk("drop_during_init", bus.o_drop_cnt, 8'd1);
    tick(24);
    set_upd(32'h708, 32'h800, 1'b0, 1'b0, 32'h0); tick(1); clear_in();
    chk("pending_drain", {bus.o_btb_we, bus.o_btb_inv, bus.o_busy, bus.o_btb_idx,
                          bus.o_btb_tag, bus.o_btb_target, bus.o_btb_taken},
        {1'b1, 1'b0, 1'b0, 5'd1, 25'hA, 32'h600, 1'b1});
    tick(1);
    chk("stage_drain", {bus.o_btb_we, bus.o_btb_inv, bus.o_btb_idx, bus.o_btb_tag,
                        bus.o_btb_target, bus.o_btb_taken},
        {1'b1, 1'b0, 5'd2, 25'hE, 32'h800, 1'b0});
    tick(2);

    // Drop counter saturation under continuous flush + update pressure
    bus.i_flush_req = 1'b1;
    set_upd(32'h900, 32'h940, 1'b1, 1'b1, 32'h940);
    tick(320); clear_in();
    tick(40);
    chk("drop_saturate", bus.o_drop_cnt, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
